// File: rtl/link_capture_multi_if.sv
// link_capture_multi_if
//   Single-cycle read port between the capture buffers and the readout logic.
//   master : readout side (drives rd_en / rd_ch / rd_addr, receives rd_data / rd_valid)
//   slave  : capture block (receives the request, returns data one cycle later)
interface link_capture_multi_if #(
    parameter int NCH        = 4,
    parameter int WORD_W     = 32,
    parameter int DEPTH_LOG2 = 9
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic                  rd_en;
    logic [CHW-1:0]        rd_ch;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [WORD_W-1:0]     rd_data;
    logic                  rd_valid;

    modport master (
        output rd_en, rd_ch, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  rd_en, rd_ch, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/link_capture_multi.sv
// link_capture_multi
//   Captures NCH aligned WORD_W-bit link streams into per-channel buffers on a
//   common word strobe (registered data_valid[0]). Capture starts on a rising
//   edge of aquire and is triggered immediately, by L1A plus a strobe delay,
//   by a BX-counter match, or by the orbit marker.
//
// Ports
//   clk160, rstb           clock, asynchronous active-low reset
//   data_in, data_valid    per-channel words and word valids
//   capture_mode           0 immediate, 1 L1A+offset, 2 BX match, 3 orbit
//   L1A_in, orbit_sync     trigger pulse, orbit marker (clears BX counter)
//   L1A_offset_or_bx       strobe delay (mode 1) or target BX (mode 2)
//   aquire, aquire_length  arm level (rise arms, low aborts), words to capture
//   rd_if                  read port (slave side), latency 1, read-first
//   waiting_for_trig, writing, done, words_written, bx_count  status
//
// Optional build macro CAPTURE_TIMESTAMP_EN adds trig_bx / trig_valid: the BX
// number of the first word stored by each capture.
module link_capture_multi #(
    parameter int NCH        = 4,
    parameter int WORD_W     = 32,
    parameter int DEPTH_LOG2 = 9,
    parameter int BX_MAX     = 3563
) (
    input  logic                    clk160,
    input  logic                    rstb,
    input  logic [NCH*WORD_W-1:0]   data_in,
    input  logic [NCH-1:0]          data_valid,
    input  logic [1:0]              capture_mode,
    input  logic                    L1A_in,
    input  logic [11:0]             L1A_offset_or_bx,
    input  logic                    orbit_sync,
    input  logic                    aquire,
    input  logic [DEPTH_LOG2:0]     aquire_length,
    link_capture_multi_if.slave     rd_if,
    output logic                    waiting_for_trig,
    output logic                    writing,
    output logic                    done,
    output logic [DEPTH_LOG2:0]     words_written,
    output logic [11:0]             bx_count
`ifdef CAPTURE_TIMESTAMP_EN
    ,
    output logic [11:0]             trig_bx,
    output logic                    trig_valid
`endif
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_DELAY = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic                  aquire_q, aquire_d;
    logic                  strb_q, strb_d;
    logic [WORD_W-1:0]     hold_q [NCH];
    logic [WORD_W-1:0]     hold_d [NCH];
    logic [11:0]           bx_q, bx_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   ww_q, ww_d;
    logic [DEPTH_LOG2:0]   len_q, len_d;
    logic [1:0]            mode_q, mode_d;
    logic [11:0]           dly_q, dly_d;
    logic [WORD_W-1:0]     rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [11:0]           ts_bx_q, ts_bx_d;
    logic                  ts_valid_q, ts_valid_d;

    logic [WORD_W-1:0]     mem_q [NCH][2**DEPTH_LOG2];

    logic                  aq_rise;
    logic                  start;
    logic                  wr_en;
    logic [DEPTH_LOG2:0]   eff_len;

    assign aq_rise = aquire & ~aquire_q;
    assign eff_len = (aquire_length > DEPTH) ? DEPTH : aquire_length;

    always_comb begin
        aquire_d = aquire;
        strb_d   = data_valid[0];
        for (int unsigned k = 0; k < NCH; k++) begin
            hold_d[k] = data_valid[k] ? data_in[k*WORD_W +: WORD_W] : hold_q[k];
        end
        // orbit_sync wins over a coincident strobe
        if (orbit_sync) begin
            bx_d = '0;
        end else if (strb_q) begin
            bx_d = (bx_q == 12'(BX_MAX)) ? '0 : bx_q + 12'd1;
        end else begin
            bx_d = bx_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        ww_d     = ww_q;
        len_d    = len_q;
        mode_d   = mode_q;
        dly_d    = dly_q;
        wr_en    = 1'b0;
        start    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (aq_rise) begin
                    start    = 1'b1;
                    wr_ptr_d = '0;
                    ww_d     = '0;
                    len_d    = eff_len;
                    mode_d   = capture_mode;
                    if (eff_len == '0)             state_d = S_DONE;
                    else if (capture_mode == 2'd0) state_d = S_WRITE;
                    else                           state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!aquire) begin
                    state_d = S_IDLE;
                end else begin
                    case (mode_q)
                        2'd1: begin
                            if (L1A_in) begin
                                dly_d   = L1A_offset_or_bx;
                                state_d = (L1A_offset_or_bx == '0) ? S_WRITE : S_DELAY;
                            end
                        end
                        2'd2: begin
                            // the matching strobe is itself the first stored word
                            if (strb_q && (bx_q == L1A_offset_or_bx)) wr_en = 1'b1;
                        end
                        2'd3: begin
                            if (orbit_sync) state_d = S_WRITE;
                        end
                        default: state_d = S_WRITE;
                    endcase
                end
            end
            S_DELAY: begin
                if (!aquire) begin
                    state_d = S_IDLE;
                end else if (strb_q) begin
                    dly_d = dly_q - 12'd1;
                    if (dly_q == 12'd1) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!aquire)     state_d = S_IDLE;
                else if (strb_q) wr_en   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            ww_d     = ww_q + 1'b1;
            state_d  = ((ww_q + 1'b1) == len_q) ? S_DONE : S_WRITE;
        end
    end

    always_comb begin
        ts_bx_d    = ts_bx_q;
        ts_valid_d = ts_valid_q;
        if (start) begin
            ts_bx_d    = '0;
            ts_valid_d = 1'b0;
        end else if (wr_en && (ww_q == '0)) begin
            ts_bx_d    = bx_q;
            ts_valid_d = 1'b1;
        end
    end

    always_comb begin
        rd_valid_d = rd_if.rd_en;
        rd_data_d  = rd_data_q;
        if (rd_if.rd_en) begin
            rd_data_d = '0;
            for (int unsigned k = 0; k < NCH; k++) begin
                if (rd_if.rd_ch == CHW'(k)) rd_data_d = mem_q[k][rd_if.rd_addr];
            end
        end
    end

    always_ff @(posedge clk160 or negedge rstb) begin
        if (!rstb) begin
            state_q    <= S_IDLE;
            aquire_q   <= 1'b0;
            strb_q     <= 1'b0;
            for (int unsigned k = 0; k < NCH; k++) hold_q[k] <= '0;
            bx_q       <= '0;
            wr_ptr_q   <= '0;
            ww_q       <= '0;
            len_q      <= '0;
            mode_q     <= '0;
            dly_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ts_bx_q    <= '0;
            ts_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            aquire_q   <= aquire_d;
            strb_q     <= strb_d;
            for (int unsigned k = 0; k < NCH; k++) hold_q[k] <= hold_d[k];
            bx_q       <= bx_d;
            wr_ptr_q   <= wr_ptr_d;
            ww_q       <= ww_d;
            len_q      <= len_d;
            mode_q     <= mode_d;
            dly_q      <= dly_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ts_bx_q    <= ts_bx_d;
            ts_valid_q <= ts_valid_d;
        end
    end

    // buffer storage is not reset
    always_ff @(posedge clk160) begin
        if (wr_en) begin
            for (int unsigned k = 0; k < NCH; k++) mem_q[k][wr_ptr_q] <= hold_q[k];
        end
    end

    assign rd_if.rd_data    = rd_data_q;
    assign rd_if.rd_valid   = rd_valid_q;
    assign waiting_for_trig = (state_q == S_ARMED);
    assign writing          = (state_q == S_WRITE);
    assign done             = (state_q == S_DONE);
    assign words_written    = ww_q;
    assign bx_count         = bx_q;

`ifdef CAPTURE_TIMESTAMP_EN
    assign trig_bx    = ts_bx_q;
    assign trig_valid = ts_valid_q;
`else
    logic ts_unused;
    assign ts_unused = ^{ts_bx_q, ts_valid_q};
`endif

endmodule

// File: tb/tb_link_capture_multi.sv
module tb_link_capture_multi;

    logic         clk160;
    logic         rstb;
    logic [127:0] data_in;
    logic [3:0]   data_valid;
    logic [1:0]   capture_mode;
    logic         L1A_in;
    logic [11:0]  L1A_offset_or_bx;
    logic         orbit_sync;
    logic         aquire;
    logic [9:0]   aquire_length;
    logic         waiting_for_trig;
    logic         writing;
    logic         done;
    logic [9:0]   words_written;
    logic [11:0]  bx_count;
`ifdef CAPTURE_TIMESTAMP_EN
    logic [11:0]  trig_bx;
    logic         trig_valid;
`endif

    link_capture_multi_if #(.NCH(4), .WORD_W(32), .DEPTH_LOG2(9)) rd_bus ();

    link_capture_multi #(.NCH(4), .WORD_W(32), .DEPTH_LOG2(9), .BX_MAX(3563)) dut (
        .clk160           (clk160),
        .rstb             (rstb),
        .data_in          (data_in),
        .data_valid       (data_valid),
        .capture_mode     (capture_mode),
        .L1A_in           (L1A_in),
        .L1A_offset_or_bx (L1A_offset_or_bx),
        .orbit_sync       (orbit_sync),
        .aquire           (aquire),
        .aquire_length    (aquire_length),
        .rd_if            (rd_bus),
        .waiting_for_trig (waiting_for_trig),
        .writing          (writing),
        .done             (done),
        .words_written    (words_written),
        .bx_count         (bx_count)
`ifdef CAPTURE_TIMESTAMP_EN
        ,
        .trig_bx          (trig_bx),
        .trig_valid       (trig_valid)
`endif
    );

    initial clk160 = 1'b0;
    always #5 clk160 = ~clk160;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // model of the per-channel hold registers
    logic [31:0] tb_hold [4];

    typedef struct {
        int unsigned len;
        int unsigned nstb;
        int unsigned gap;
        int unsigned exp_ww;
        logic        exp_done;
        logic        exp_writing;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk160);
        #1;
    endtask

    function automatic logic [31:0] pat(input int unsigned k, input int unsigned n);
        return 32'hA000_0000 + 32'(k) * 32'h100 + 32'(n);
    endfunction

    task automatic drive_strobe(input logic [127:0] w, input logic [3:0] v);
        data_in    = w;
        data_valid = v | 4'b0001;
        for (int k = 0; k < 4; k++) if (data_valid[k]) tb_hold[k] = w[k*32 +: 32];
        tick();
        data_valid = '0;
    endtask

    task automatic strobe_pat(input int unsigned n, input int unsigned gap);
        logic [127:0] w;
        for (int k = 0; k < 4; k++) w[k*32 +: 32] = pat(k, n);
        drive_strobe(w, 4'hF);
        repeat (gap) tick();
    endtask

    task automatic arm(input logic [1:0] mode, input int unsigned len, input int unsigned off);
        aquire = 1'b0;
        tick();
        tick();
        capture_mode     = mode;
        aquire_length    = 10'(len);
        L1A_offset_or_bx = 12'(off);
        aquire           = 1'b1;
        tick();
    endtask

    task automatic do_read(input int unsigned ch, input int unsigned addr,
                           output logic [31:0] d, output logic v);
        rd_bus.rd_en   = 1'b1;
        rd_bus.rd_ch   = 2'(ch);
        rd_bus.rd_addr = 9'(addr);
        tick();
        d = rd_bus.rd_data;
        v = rd_bus.rd_valid;
        rd_bus.rd_en = 1'b0;
    endtask

    task automatic pulse_l1a();
        L1A_in = 1'b1;
        tick();
        L1A_in = 1'b0;
    endtask

    task automatic pulse_orbit();
        orbit_sync = 1'b1;
        tick();
        orbit_sync = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d_prev;
        logic        v;
        logic [127:0] w;
        logic [31:0] seen [32][4];
        int unsigned mode, len, off, p, first, total, ch;

        vecs[0] = '{8,    8,   3, 8,   1'b1, 1'b0};
        vecs[1] = '{8,    5,   1, 5,   1'b0, 1'b1};
        vecs[2] = '{1,    3,   0, 1,   1'b1, 1'b0};
        vecs[3] = '{0,    4,   2, 0,   1'b1, 1'b0};
        vecs[4] = '{3,    10,  0, 3,   1'b1, 1'b0};
        vecs[5] = '{513,  515, 0, 512, 1'b1, 1'b0};
        vecs[6] = '{1023, 514, 0, 512, 1'b1, 1'b0};

        rstb = 1'b0;
        data_in = '0; data_valid = '0; capture_mode = '0; L1A_in = 1'b0;
        L1A_offset_or_bx = '0; orbit_sync = 1'b0; aquire = 1'b0; aquire_length = '0;
        rd_bus.rd_en = 1'b0; rd_bus.rd_ch = '0; rd_bus.rd_addr = '0;
        for (int k = 0; k < 4; k++) tb_hold[k] = '0;
        #23 rstb = 1'b1;
        tick();

        // reset state
        check("rst_ww", 32'(words_written), 0);
        check("rst_done", 32'(done), 0);
        check("rst_writing", 32'(writing), 0);
        check("rst_waiting", 32'(waiting_for_trig), 0);
        check("rst_bx", 32'(bx_count), 0);
        check("rst_rd_valid", 32'(rd_bus.rd_valid), 0);
        check("rst_rd_data", rd_bus.rd_data, 0);
`ifdef CAPTURE_TIMESTAMP_EN
        check("rst_trig_valid", 32'(trig_valid), 0);
`endif

        // mode 0, strobe every 4 clocks, length 8
        arm(2'd0, 8, 0);
        check("m0_writing", 32'(writing), 1);
        for (int n = 0; n < 8; n++) strobe_pat(n, 3);
        check("m0_done", 32'(done), 1);
        check("m0_writing_off", 32'(writing), 0);
        check("m0_ww", 32'(words_written), 8);
        check("m0_rd_valid_pre", 32'(rd_bus.rd_valid), 0);
        do_read(2, 5, d, v);
        check("m0_rd_data", d, 32'hA000_0205);
        check("m0_rd_valid", 32'(v), 1);
        d_prev = d;
        tick();
        check("m0_rd_valid_drop", 32'(rd_bus.rd_valid), 0);
        check("m0_rd_data_hold", rd_bus.rd_data, d_prev);

        // table: lengths, boundaries, clamp
        for (int i = 0; i < 7; i++) begin
            arm(2'd0, vecs[i].len, 0);
            for (int n = 0; n < int'(vecs[i].nstb); n++) strobe_pat(n, vecs[i].gap);
            tick();
            tick();
            check($sformatf("vec%0d_ww", i), 32'(words_written), vecs[i].exp_ww);
            check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d_writing", i), 32'(writing), 32'(vecs[i].exp_writing));
            if (vecs[i].exp_ww > 0) begin
                do_read(2, vecs[i].exp_ww - 1, d, v);
                check($sformatf("vec%0d_last", i), d, pat(2, vecs[i].exp_ww - 1));
                do_read(0, 0, d, v);
                check($sformatf("vec%0d_first", i), d, pat(0, 0));
            end
            aquire = 1'b0;
            tick();
        end

        // mode 1, offset 3
        arm(2'd1, 4, 3);
        check("m1_waiting", 32'(waiting_for_trig), 1);
        strobe_pat(100, 2);
        strobe_pat(101, 2);
        check("m1_ww_armed", 32'(words_written), 0);
        L1A_in = 1'b1;
        check("m1_waiting_l1a_cycle", 32'(waiting_for_trig), 1);
        tick();
        L1A_in = 1'b0;
        check("m1_waiting_after", 32'(waiting_for_trig), 0);
        for (int n = 0; n < 8; n++) strobe_pat(n, 3);
        check("m1_done", 32'(done), 1);
        check("m1_ww", 32'(words_written), 4);
        do_read(1, 0, d, v);
        check("m1_first", d, pat(1, 3));
        do_read(0, 3, d, v);
        check("m1_last", d, pat(0, 6));

        // mode 2, target BX 10
        arm(2'd2, 4, 10);
        pulse_orbit();
        check("m2_bx_orbit", 32'(bx_count), 0);
        for (int n = 0; n < 16; n++) strobe_pat(n, 1);
        check("m2_done", 32'(done), 1);
        check("m2_bx", 32'(bx_count), 16);
        do_read(3, 0, d, v);
        check("m2_first", d, pat(3, 10));
        do_read(3, 3, d, v);
        check("m2_last", d, pat(3, 13));
`ifdef CAPTURE_TIMESTAMP_EN
        check("m2_trig_bx", 32'(trig_bx), 10);
        check("m2_trig_valid", 32'(trig_valid), 1);
`endif

        // BX wrap and orbit priority
        aquire = 1'b0;
        pulse_orbit();
        for (int n = 0; n < 3563; n++) strobe_pat(n, 0);
        tick();
        check("bx_max", 32'(bx_count), 3563);
        strobe_pat(0, 1);
        check("bx_wrap", 32'(bx_count), 0);
        for (int n = 0; n < 5; n++) strobe_pat(n, 0);
        tick();
        check("bx_five", 32'(bx_count), 5);
        data_valid = 4'hF;
        tick();
        data_valid = '0;
        orbit_sync = 1'b1;
        tick();
        orbit_sync = 1'b0;
        check("bx_orbit_vs_strb", 32'(bx_count), 0);
        tick();
        check("bx_orbit_hold", 32'(bx_count), 0);

        // abort after 3 of 8
        arm(2'd0, 8, 0);
        for (int n = 0; n < 3; n++) strobe_pat(n, 2);
        aquire = 1'b0;
        tick();
        check("abort_writing", 32'(writing), 0);
        check("abort_done", 32'(done), 0);
        check("abort_ww", 32'(words_written), 3);
        arm(2'd0, 8, 0);
        check("rearm_ww", 32'(words_written), 0);
        check("rearm_writing", 32'(writing), 1);
        aquire = 1'b0;
        tick();

        // randomized captures against the strobe-index model
        for (int it = 0; it < 24; it++) begin
            mode  = $urandom_range(0, 3);
            len   = $urandom_range(1, 12);
            off   = (mode == 1) ? $urandom_range(0, 5) : (mode == 2) ? $urandom_range(0, 10) : 0;
            p     = (mode == 1 || mode == 3) ? $urandom_range(0, 3) : 0;
            first = (mode == 1) ? p + off : (mode == 2) ? off : p;
            total = first + len + $urandom_range(0, 3);

            pulse_l1a();
            arm(2'(mode), len, off);
            if (mode == 2) pulse_orbit();
            for (int j = 0; j < int'(total); j++) begin
                if (j == int'(p) && mode == 1) pulse_l1a();
                if (j == int'(p) && mode == 3) pulse_orbit();
                if (j == int'(p) + 1 && mode == 1) pulse_l1a();
                for (int k = 0; k < 4; k++) w[k*32 +: 32] = $urandom;
                drive_strobe(w, 4'($urandom_range(0, 15)));
                for (int k = 0; k < 4; k++) seen[j][k] = tb_hold[k];
                repeat ($urandom_range(1, 3)) tick();
            end
            tick();
            check($sformatf("rnd%0d_m%0d_done", it, mode), 32'(done), 1);
            check($sformatf("rnd%0d_m%0d_ww", it, mode), 32'(words_written), len);
            for (int i = 0; i < int'(len); i++) begin
                ch = $urandom_range(0, 3);
                do_read(ch, i, d, v);
                check($sformatf("rnd%0d_ch%0d_a%0d", it, ch, i), d, seen[first + i][ch]);
            end
        end

        // async reset in the middle of a capture
        arm(2'd0, 8, 0);
        strobe_pat(0, 2);
        strobe_pat(1, 2);
        do_read(0, 1, d, v);
        #2 rstb = 1'b0;
        #1;
        check("areset_writing", 32'(writing), 0);
        check("areset_ww", 32'(words_written), 0);
        check("areset_bx", 32'(bx_count), 0);
        check("areset_done", 32'(done), 0);
        check("areset_rd_data", rd_bus.rd_data, 0);
        aquire = 1'b0;
        for (int k = 0; k < 4; k++) tb_hold[k] = '0;
        #2 rstb = 1'b1;
        tick();
        check("areset_writing_after", 32'(writing), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
